// File: rtl/sdram_rd_checker.sv
// -----------------------------------------------------------------------------
// sdram_rd_checker
//
// Checks one SDRAM read burst against a generated data pattern. A start pulse
// arms the checker with a burst length, seed, pattern mode and base address.
// Each rd_ack strobe is compared with the expected word, and the pattern then
// advances. The burst ends on its last word, or when rd_ack stays quiet for
// TIMEOUT cycles. The result is held until the next accepted start.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle arm request (accepted only in IDLE)
//   burst_len, seed, mode,   burst parameters, sampled on an accepted start
//   base_addr
//   rd_ack, rd_data          controller read-data strobe and data
//   clr                      synchronous clear of the sticky flags
//   busy, done               checking in progress / one-cycle completion pulse
//   pass, timeout, err_count result of the current or last burst
//   first_err_addr/_data/_exp  address, received word and expected word of the
//                              first mismatch in the burst
//   any_err, overrun         sticky error flags
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; rd_ack here is an overrun
// CHECK  | comparing rd_data on every rd_ack, idle timer running
// DONE   | one-cycle completion; done=1, pass/timeout valid
// -----------------------------------------------------------------------------
module sdram_rd_checker #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 23,
    parameter int LEN_W   = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] seed,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic              timeout,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp,
    output logic              any_err,
    output logic              overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_INC   = 2'b00;
    localparam logic [1:0] MODE_CONST = 2'b01;
    localparam logic [1:0] MODE_ROTL  = 2'b10;

    // Idle timer is a down-counter: loaded with TIMEOUT-1 on every rd_ack and
    // on entry to CHECK, and a quiet cycle at zero ends the burst. This gives
    // exactly TIMEOUT quiet cycles between the last ack and the DONE state.
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    logic [1:0]        state_q,          state_d;
    logic [LEN_W-1:0]  len_q,            len_d;
    logic [1:0]        mode_q,           mode_d;
    logic [ADDR_W-1:0] base_q,           base_d;
    logic [DATA_W-1:0] exp_q,            exp_d;
    logic [LEN_W-1:0]  idx_q,            idx_d;
    logic [TMR_W-1:0]  tmr_q,            tmr_d;
    logic              pass_q,           pass_d;
    logic              timeout_q,        timeout_d;
    logic [15:0]       err_count_q,      err_count_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
    logic [DATA_W-1:0] first_err_exp_q,  first_err_exp_d;
    logic              any_err_q,        any_err_d;
    logic              overrun_q,        overrun_d;

    logic              mismatch;
    logic              last_word;
    logic              any_err_set;
    logic              overrun_set;
    logic [DATA_W-1:0] exp_next;

    assign mismatch  = (rd_data != exp_q);
    assign last_word = (idx_q == (len_q - LEN_W'(1)));

    // Mode 11 is not defined as a pattern of its own and falls back to increment.
    always_comb begin
        exp_next = exp_q + DATA_W'(1);
        case (mode_q)
            MODE_INC:   exp_next = exp_q + DATA_W'(1);
            MODE_CONST: exp_next = exp_q;
            MODE_ROTL:  exp_next = {exp_q[DATA_W-2:0], exp_q[DATA_W-1]};
            default:    exp_next = exp_q + DATA_W'(1);
        endcase
    end

    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        mode_d           = mode_q;
        base_d           = base_q;
        exp_d            = exp_q;
        idx_d            = idx_q;
        tmr_d            = tmr_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        first_err_exp_d  = first_err_exp_q;
        any_err_set      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d            = burst_len;
                    mode_d           = mode;
                    base_d           = base_addr;
                    exp_d            = seed;
                    idx_d            = '0;
                    tmr_d            = TMR_LOAD;
                    timeout_d        = 1'b0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    first_err_data_d = '0;
                    first_err_exp_d  = '0;
                    if (burst_len != '0) begin
                        pass_d  = 1'b0;
                        state_d = ST_CHECK;
                    end else begin
                        // Empty burst: nothing to check, trivially passes.
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_CHECK: begin
                if (rd_ack) begin
                    idx_d = idx_q + LEN_W'(1);
                    exp_d = exp_next;
                    tmr_d = TMR_LOAD;
                    if (mismatch) begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (err_count_q == 16'd0) begin
                            first_err_addr_d = base_q + ADDR_W'(idx_q);
                            first_err_data_d = rd_data;
                            first_err_exp_d  = exp_q;
                        end
                    end
                    // Result is resolved on the way into DONE so that pass and
                    // any_err are already valid while done is high.
                    if (last_word) begin
                        state_d     = ST_DONE;
                        pass_d      = (err_count_d == 16'd0);
                        any_err_set = (err_count_d != 16'd0);
                    end
                end else if (tmr_q == '0) begin
                    state_d     = ST_DONE;
                    timeout_d   = 1'b1;
                    pass_d      = 1'b0;
                    any_err_set = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a new set condition takes priority over clr in the same cycle.
    always_comb begin
        overrun_set = rd_ack && (state_q != ST_CHECK);

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (any_err_set) begin
            any_err_d = 1'b1;
        end else if (clr) begin
            any_err_d = 1'b0;
        end else begin
            any_err_d = any_err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            len_q            <= '0;
            mode_q           <= '0;
            base_q           <= '0;
            exp_q            <= '0;
            idx_q            <= '0;
            tmr_q            <= '0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            any_err_q        <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            mode_q           <= mode_d;
            base_q           <= base_d;
            exp_q            <= exp_d;
            idx_q            <= idx_d;
            tmr_q            <= tmr_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            first_err_exp_q  <= first_err_exp_d;
            any_err_q        <= any_err_d;
            overrun_q        <= overrun_d;
        end
    end

    assign busy           = (state_q == ST_CHECK);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;
    assign any_err        = any_err_q;
    assign overrun        = overrun_q;

endmodule
